fg_burst_exec: RTL and testbench

Consumer end of the flow generator's burst descriptor interface. Accepts burst descriptors (dest, burst length in bytes) and emits each burst as an 8-bit AXI-stream byte sequence. Long bursts are split into packets of at most MAX_PKT_LEN bytes, and every packet carries the descriptor's dest on tdest. Sits directly downstream of the burst generator and feeds the MAC/traffic sink.

---
 rtl/fg_pkg.sv | 34 +++
 rtl/fg_axis_out_reg.sv | 65 ++++++
 rtl/fg_burst_exec.sv | 174 +++++++++++++++++
 tb/tb_fg_burst_exec.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// +----------------------------------------------------------------------------+
// | fg_pkg : shared types and constants for the flow-generator burst blocks.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fg_pkg;

    localparam int FG_LEN_WIDTH     = 32;
    localparam int FG_PKT_CNT_WIDTH = 16;
    localparam int FG_DEST_WIDTH    = 8;

    typedef enum logic [0:0] {
        FG_EXEC_IDLE = 1'b0,
        FG_EXEC_XFER = 1'b1
    } fg_exec_state_e;

    typedef struct packed {
        logic [FG_DEST_WIDTH-1:0] dest;
        logic [FG_LEN_WIDTH-1:0]  burst_len;
    } fg_bd_t;

    // A byte closes its packet if it is the last of the burst or fills the packet.
    function automatic logic fg_is_pkt_end(
        input logic [FG_LEN_WIDTH-1:0]     rem,
        input logic [FG_PKT_CNT_WIDTH-1:0] pkt_cnt,
        input logic [FG_PKT_CNT_WIDTH-1:0] pkt_cnt_max
    );
        return (rem == FG_LEN_WIDTH'(1)) || (pkt_cnt == pkt_cnt_max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fg_axis_out_reg.sv
// +----------------------------------------------------------------------------+
// | fg_axis_out_reg : single-entry AXI-stream output holding register.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fg_axis_out_reg #(
    parameter int DEST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [7:0]            data_i,
    input  logic                  last_i,
    input  logic [DEST_WIDTH-1:0] dest_i,
    input  logic                  tready_i,
    output logic                  tvalid_o,
    output logic [7:0]            tdata_o,
    output logic                  tlast_o,
    output logic [DEST_WIDTH-1:0] tdest_o
);

    logic                  tvalid_q, tvalid_d;
    logic [7:0]            tdata_q,  tdata_d;
    logic                  tlast_q,  tlast_d;
    logic [DEST_WIDTH-1:0] tdest_q,  tdest_d;

    // Payload only changes on a load, so it stays stable during a stall.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tdest_d  = tdest_q;
        if (load_i) begin
            tvalid_d = 1'b1;
            tdata_d  = data_i;
            tlast_d  = last_i;
            tdest_d  = dest_i;
        end else if (tready_i) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= 8'd0;
            tlast_q  <= 1'b0;
            tdest_q  <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tdest_q  <= tdest_d;
        end
    end

    assign tvalid_o = tvalid_q;
    assign tdata_o  = tdata_q;
    assign tlast_o  = tlast_q;
    assign tdest_o  = tdest_q;

endmodule

`default_nettype wire

// File: rtl/fg_burst_exec.sv
// +----------------------------------------------------------------------------+
// | fg_burst_exec : turns burst descriptors into packetised AXI-stream bytes.  |
// | Optional statistics counters: define FG_BURST_EXEC_STATS_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fg_burst_exec
    import fg_pkg::*;
#(
    parameter int DEST_WIDTH  = 8,
    parameter int MAX_PKT_LEN = 1514
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    input_bd_valid,
    output logic                    input_bd_ready,
    input  logic [DEST_WIDTH-1:0]   input_bd_dest,
    input  logic [FG_LEN_WIDTH-1:0] input_bd_burst_len,
    output logic [7:0]              output_axis_tdata,
    output logic                    output_axis_tvalid,
    input  logic                    output_axis_tready,
    output logic                    output_axis_tlast,
    output logic [DEST_WIDTH-1:0]   output_axis_tdest,
    output logic                    busy
`ifdef FG_BURST_EXEC_STATS_EN
    ,
    input  logic                    stat_clear,
    output logic [31:0]             stat_bursts,
    output logic [31:0]             stat_packets,
    output logic [31:0]             stat_bytes
`endif
);

    localparam logic [FG_PKT_CNT_WIDTH-1:0] PKT_CNT_MAX = FG_PKT_CNT_WIDTH'(MAX_PKT_LEN - 1);

    fg_exec_state_e              state_q,   state_d;
    logic                        ready_q,   ready_d;
    logic [DEST_WIDTH-1:0]       dest_q,    dest_d;
    logic [FG_LEN_WIDTH-1:0]     rem_q,     rem_d;
    logic [FG_LEN_WIDTH-1:0]     off_q,     off_d;
    logic [FG_PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    logic bd_hs;
    logic load;
    logic load_last;
    logic out_tvalid;

    assign bd_hs     = input_bd_valid & ready_q;
    assign load      = (state_q == FG_EXEC_XFER) & (~out_tvalid | output_axis_tready);
    assign load_last = fg_is_pkt_end(rem_q, pkt_cnt_q, PKT_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FG_EXEC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FG_EXEC_IDLE: begin
                if (bd_hs && (input_bd_burst_len != '0)) begin
                    state_d = FG_EXEC_XFER;
                end
            end
            FG_EXEC_XFER: begin
                if (load && (rem_q == FG_LEN_WIDTH'(1))) begin
                    state_d = FG_EXEC_IDLE;
                end
            end
            default: state_d = FG_EXEC_IDLE;
        endcase
    end

    // Ready looks ahead one cycle so the next descriptor is taken as the last byte drains.
    always_comb begin
        ready_d = (state_d == FG_EXEC_IDLE) & (~out_tvalid | output_axis_tready);
        busy    = (state_q == FG_EXEC_XFER) | out_tvalid;
    end

    always_comb begin
        dest_d    = dest_q;
        rem_d     = rem_q;
        off_d     = off_q;
        pkt_cnt_d = pkt_cnt_q;
        if (bd_hs) begin
            dest_d    = input_bd_dest;
            rem_d     = input_bd_burst_len;
            off_d     = '0;
            pkt_cnt_d = '0;
        end else if (load) begin
            rem_d     = rem_q - FG_LEN_WIDTH'(1);
            off_d     = off_q + FG_LEN_WIDTH'(1);
            pkt_cnt_d = load_last ? '0 : pkt_cnt_q + FG_PKT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            dest_q    <= '0;
            rem_q     <= '0;
            off_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            ready_q   <= ready_d;
            dest_q    <= dest_d;
            rem_q     <= rem_d;
            off_q     <= off_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign input_bd_ready = ready_q;

    fg_axis_out_reg #(
        .DEST_WIDTH (DEST_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .data_i   (off_q[7:0]),
        .last_i   (load_last),
        .dest_i   (dest_q),
        .tready_i (output_axis_tready),
        .tvalid_o (out_tvalid),
        .tdata_o  (output_axis_tdata),
        .tlast_o  (output_axis_tlast),
        .tdest_o  (output_axis_tdest)
    );

    assign output_axis_tvalid = out_tvalid;

`ifdef FG_BURST_EXEC_STATS_EN
    logic [31:0] stat_bursts_q;
    logic [31:0] stat_packets_q;
    logic [31:0] stat_bytes_q;
    logic        beat_hs;

    assign beat_hs = out_tvalid & output_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bursts_q  <= 32'd0;
            stat_packets_q <= 32'd0;
            stat_bytes_q   <= 32'd0;
        end else if (stat_clear) begin
            stat_bursts_q  <= 32'd0;
            stat_packets_q <= 32'd0;
            stat_bytes_q   <= 32'd0;
        end else begin
            if (bd_hs) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
            end
            if (beat_hs && output_axis_tlast) begin
                stat_packets_q <= stat_packets_q + 32'd1;
            end
            if (beat_hs) begin
                stat_bytes_q <= stat_bytes_q + 32'd1;
            end
        end
    end

    assign stat_bursts  = stat_bursts_q;
    assign stat_packets = stat_packets_q;
    assign stat_bytes   = stat_bytes_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fg_burst_exec.sv
// +----------------------------------------------------------------------------+
// | tb_fg_burst_exec : scoreboard bench for fg_burst_exec (MAX_PKT_LEN 1514/4/1)|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fg_burst_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bd_valid;
    logic [7:0]  bd_dest;
    logic [31:0] bd_len;
    logic        out_tready;
    logic        stat_clear;

    logic       ready0, tvalid0, tlast0, busy0;
    logic [7:0] tdata0, tdest0;
    logic       ready4, tvalid4, tlast4, busy4;
    logic [7:0] tdata4, tdest4;
    logic       ready1, tvalid1, tlast1, busy1;
    logic [7:0] tdata1, tdest1;

`ifdef FG_BURST_EXEC_STATS_EN
    logic [31:0] sb0, sp0, sy0, sb4, sp4, sy4, sb1, sp1, sy1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [16:0] q0[$];
    logic [16:0] q4[$];
    logic [16:0] q1[$];

    logic        stall_q = 1'b0;
    logic [16:0] stall_v = '0;

    always #5 clk = ~clk;

    fg_burst_exec #(.DEST_WIDTH(8), .MAX_PKT_LEN(1514)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .input_bd_valid(bd_valid), .input_bd_ready(ready0),
        .input_bd_dest(bd_dest), .input_bd_burst_len(bd_len),
        .output_axis_tdata(tdata0), .output_axis_tvalid(tvalid0),
        .output_axis_tready(out_tready), .output_axis_tlast(tlast0),
        .output_axis_tdest(tdest0), .busy(busy0)
`ifdef FG_BURST_EXEC_STATS_EN
        , .stat_clear(stat_clear), .stat_bursts(sb0), .stat_packets(sp0), .stat_bytes(sy0)
`endif
    );

    fg_burst_exec #(.DEST_WIDTH(8), .MAX_PKT_LEN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .input_bd_valid(bd_valid), .input_bd_ready(ready4),
        .input_bd_dest(bd_dest), .input_bd_burst_len(bd_len),
        .output_axis_tdata(tdata4), .output_axis_tvalid(tvalid4),
        .output_axis_tready(out_tready), .output_axis_tlast(tlast4),
        .output_axis_tdest(tdest4), .busy(busy4)
`ifdef FG_BURST_EXEC_STATS_EN
        , .stat_clear(stat_clear), .stat_bursts(sb4), .stat_packets(sp4), .stat_bytes(sy4)
`endif
    );

    fg_burst_exec #(.DEST_WIDTH(8), .MAX_PKT_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .input_bd_valid(bd_valid), .input_bd_ready(ready1),
        .input_bd_dest(bd_dest), .input_bd_burst_len(bd_len),
        .output_axis_tdata(tdata1), .output_axis_tvalid(tvalid1),
        .output_axis_tready(out_tready), .output_axis_tlast(tlast1),
        .output_axis_tdest(tdest1), .busy(busy1)
`ifdef FG_BURST_EXEC_STATS_EN
        , .stat_clear(stat_clear), .stat_bursts(sb1), .stat_packets(sp1), .stat_bytes(sy1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: packet position is the byte index modulo the packet size.
    task automatic push_bd(input logic [7:0] d, input int unsigned l);
        for (int unsigned i = 0; i < l; i++) begin
            q0.push_back({(i == l - 1) || (i % 1514 == 1513), d, i[7:0]});
            q4.push_back({(i == l - 1) || (i % 4 == 3), d, i[7:0]});
            q1.push_back({1'b1, d, i[7:0]});
        end
    endtask

    task automatic send_bd(input logic [7:0] d, input logic [31:0] l);
        int n;
        n = 0;
        bd_valid = 1'b1;
        bd_dest  = d;
        bd_len   = l;
        while (!ready0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bd_accept_ready", ready0, 1'b1);
        push_bd(d, l);
        @(posedge clk); #1;
        bd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((q0.size() + q4.size() + q1.size()) != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drain_pending"}, q0.size() + q4.size() + q1.size(), 0);
        @(posedge clk); #1;
        check({tag, "_busy_after"}, {busy0, busy4, busy1}, 3'b000);
    endtask

    // Scoreboard monitor: samples on the falling edge, ahead of the next rising edge.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("dut0_stall_hold", {tvalid0, tlast0, tdest0, tdata0}, {1'b1, stall_v});
            end
            stall_q = tvalid0 & ~out_tready;
            stall_v = {tlast0, tdest0, tdata0};
            if (tvalid0 && out_tready) begin
                check("dut0_beat_expected", q0.size() != 0, 1'b1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check("dut0_beat", {tlast0, tdest0, tdata0}, e);
                end
            end
            if (tvalid4 && out_tready) begin
                check("dut4_beat_expected", q4.size() != 0, 1'b1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("dut4_beat", {tlast4, tdest4, tdata4}, e);
                end
            end
            if (tvalid1 && out_tready) begin
                check("dut1_beat_expected", q1.size() != 0, 1'b1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("dut1_beat", {tlast1, tdest1, tdata1}, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] pat;
        pat        = 4'b1001;
        rst_n      = 1'b0;
        bd_valid   = 1'b0;
        bd_dest    = 8'h00;
        bd_len     = 32'd0;
        out_tready = 1'b1;
        stat_clear = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs0", {ready0, tvalid0, tlast0, tdata0, tdest0, busy0}, '0);
        check("rst_outs4", {ready4, tvalid4, tlast4, tdata4, tdest4, busy4}, '0);
        check("rst_outs1", {ready1, tvalid1, tlast1, tdata1, tdest1, busy1}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {ready0, ready4, ready1}, 3'b111);

        // Basic burst: latency and ready/busy around the accept edge.
        send_bd(8'h05, 32'd4);
        check("t1_tvalid_at_accept", tvalid0, 1'b0);
        check("t1_ready_drop", ready0, 1'b0);
        check("t1_busy", busy0, 1'b1);
        @(posedge clk); #1;
        check("t1_first_tvalid", tvalid0, 1'b1);
        check("t1_first_beat", {tlast0, tdest0, tdata0}, {1'b0, 8'h05, 8'h00});
        wait_drain("t1", 50);

        send_bd(8'h22, 32'd10);
        wait_drain("t2", 50);

        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        send_bd(8'hAA, 32'd0);
        check("t3_zero_ready", ready0, 1'b1);
        check("t3_zero_idle", {tvalid0, busy0}, 2'b00);
        send_bd(8'h07, 32'd2);
        wait_drain("t3", 50);
`ifdef FG_BURST_EXEC_STATS_EN
        check("t3_stat_bursts", sb0, 32'd2);
        check("t3_stat_packets", sp0, 32'd1);
        check("t3_stat_bytes", sy0, 32'd2);
        check("t3_stat_packets_m1", sp1, 32'd2);
`endif

        // Stalled output: ready must stay low while bytes are still to be loaded.
        send_bd(8'h3C, 32'd6);
        for (int k = 0; k < 60 && q0.size() != 0; k++) begin
            if (q0.size() >= 2) begin
                check("t4_ready_low", ready0, 1'b0);
            end
            out_tready = pat[k % 4];
            @(posedge clk); #1;
        end
        out_tready = 1'b1;
        wait_drain("t4", 50);

        send_bd(8'h11, 32'd300);
        wait_drain("t5", 400);

        send_bd(8'h99, 32'd1514);
        wait_drain("t6", 1700);

        // Reset in the middle of a burst.
        send_bd(8'h42, 32'd8);
        repeat (3) @(posedge clk);
        #1;
        check("t7_beat3_visible", {tvalid0, tdata0}, {1'b1, 8'h02});
        rst_n = 1'b0;
        #1;
        q0.delete();
        q4.delete();
        q1.delete();
        check("t7_rst_outs0", {ready0, tvalid0, tlast0, tdata0, tdest0, busy0}, '0);
        check("t7_rst_outs4", {ready4, tvalid4, tlast4, tdata4, tdest4, busy4}, '0);
        check("t7_rst_outs1", {ready1, tvalid1, tlast1, tdata1, tdest1, busy1}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t7_quiet_after_reset", {tvalid0, busy0, tvalid4, tvalid1}, 4'b0000);
        send_bd(8'h01, 32'd3);
        wait_drain("t7", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
